star_raster_scanner: RTL and testbench
======================================

Name: star_raster_scanner

Overview:
- Upstream stage of the star top/bottom finder: raster-scans the WIDTH x HEIGHT 3-bit image RAM for pixels above THRESHOLD.
- Reports each hit's (x, y) with a level flag and an active-low start pulse that restarts the downstream finder's controller.
- Waits for the finder's completion strobe, then resumes scanning from the next raster position.
- Drives its own RAM read port: 1-cycle registered-address read latency.

Parameters:
- X_SZ, 3, x coordinate width
- Y_SZ, 3, y coordinate width
- ADDR_SZ, 6, RAM address width
- COL_SZ, 3, pixel width
- WIDTH, 6, image columns
- HEIGHT, 6, image rows
- THRESHOLD, 0, pixel counts as star when pix_val > THRESHOLD

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  begin frame scan from (0,0); sampled in IDLE/DONE only
- trace_done  in  1  downstream finder complete; sampled in FOUND only
- pix_val  in  COL_SZ  RAM q, valid the cycle after mem_address is presented
- mem_address  out  ADDR_SZ  y*WIDTH + x, unsigned shift-add (y<<2 + y<<1 + x for WIDTH=6)
- x_out  out  X_SZ  x of reported star pixel
- y_out  out  Y_SZ  y of reported star pixel
- star_found  out  1  high while a report is held
- star_foundn  out  1  one-cycle low pulse on first FOUND cycle, else high
- busy  out  1  high in READ/COMPARE/FOUND
- frame_done  out  1  high in DONE until next start

Behaviour:
- Reset, including mid-operation: state IDLE; x/y counters 0; x_out = y_out = 0; star_found = 0; star_foundn = 1; busy = 0; frame_done = 0; mem_address = 0. Reset beats simultaneous start or trace_done.
- States: IDLE, READ, COMPARE, FOUND, DONE.
- IDLE: on start, clear counters, go to READ.
- READ: mem_address = f(x, y). The RAM samples this address at the end of the cycle. Go to COMPARE.
- COMPARE: pix_val is valid for the current (x, y).
  - If pix_val > THRESHOLD: latch x_out/y_out from the counters, go to FOUND.
  - Else if (x, y) = (WIDTH-1, HEIGHT-1): go to DONE.
  - Else advance and go to READ.
- Advance: if x = WIDTH-1, then x <= 0 and y <= y+1; else x <= x+1.
- FOUND: star_found = 1; star_foundn = 0 on the entry cycle only. Counters frozen. x_out/y_out stable.
  - On trace_done: if at last pixel go to DONE, else advance and go to READ. star_found drops the cycle after trace_done is sampled.
- DONE: frame_done = 1. start restarts a scan from (0,0) (frame_done drops next cycle).
- Ignored inputs: start in READ/COMPARE/FOUND; trace_done outside FOUND.
- Throughput: 2 cycles per pixel scanned. A hit at linear address n (all earlier pixels dim), with start sampled in cycle 0: star_found first high in cycle 2n+3, star_foundn low in that same cycle.
- A star on the last pixel is reported first; DONE is entered only after its trace_done.
- Counter and address arithmetic is unsigned. Counters never exceed WIDTH-1 / HEIGHT-1.

Optional Feature:
- Macro: STAR_RUN_SKIP_EN.
- Defined:
  - Leaving FOUND via trace_done sets an internal skip_run flag.
  - In COMPARE with skip_run = 1, a bright pixel is not reported; the block advances instead.
  - skip_run clears on the first dim pixel, which is then processed normally (not a hit), or when the row wraps.
  - Effect: one report per horizontal bright run.
  - Reset and start clear skip_run.
- Undefined: no flag; every bright pixel is reported individually.

Test Plan:
- Reset mid-scan: assert reset during COMPARE at (3,2) -> next cycle all outputs at reset values, state IDLE; later start rescans from address 0.
- Single star: only pixel (2,1) = 5 (addr 8), start in cycle 0 -> star_found high and star_foundn low in cycle 19, x_out = 2, y_out = 1. trace_done in cycle 25 -> scan resumes at (3,1). frame_done rises after (5,5) is compared.
- Run of three: (2,1), (3,1), (4,1) = 7 and (0,3) = 4.
  - Feature off -> reports (2,1), (3,1), (4,1), (0,3) in order.
  - STAR_RUN_SKIP_EN -> reports (2,1), (0,3) only.
- Row wrap: only (5,0) bright -> reported x_out = 5, y_out = 0. After trace_done the next mem_address is 6, i.e. (0,1).
- Last pixel: only (5,5) bright -> FOUND with mem_address 35. trace_done -> DONE, frame_done = 1. start in DONE -> mem_address 0 next READ.
- Handshake hygiene: start pulsed in FOUND and trace_done pulsed in READ -> no state change, counters unchanged. Empty frame (all 0) -> frame_done high after 72 scan cycles, star_found never asserted.

Source files
------------

// File: rtl/star_raster_scanner.sv
// Raster scanner feeding the star top/bottom finder; reports pixels above THRESHOLD.
// Optional STAR_RUN_SKIP_EN: one report per horizontal bright run.
module star_raster_scanner #(
   parameter int X_SZ      = 3,
   parameter int Y_SZ      = 3,
   parameter int ADDR_SZ   = 6,
   parameter int COL_SZ    = 3,
   parameter int WIDTH     = 6,
   parameter int HEIGHT    = 6,
   parameter int THRESHOLD = 0
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               trace_done,
   input  logic [COL_SZ-1:0]  pix_val,
   output logic [ADDR_SZ-1:0] mem_address,
   output logic [X_SZ-1:0]    x_out,
   output logic [Y_SZ-1:0]    y_out,
   output logic               star_found,
   output logic               star_foundn,
   output logic               busy,
   output logic               frame_done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_COMPARE,
      S_FOUND,
      S_DONE
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [X_SZ-1:0]   r_x;
   logic [Y_SZ-1:0]   r_y;
   logic [X_SZ-1:0]   r_x_out;
   logic [Y_SZ-1:0]   r_y_out;
   logic              r_was_found;
   logic              w_adv;
   logic              w_clr;
   logic              w_latch;
   logic              w_xmax;
   logic              w_last;
   logic              w_bright;
   logic              w_skip;

   assign w_xmax   = (r_x == X_SZ'(WIDTH - 1));
   assign w_last   = w_xmax && (r_y == Y_SZ'(HEIGHT - 1));
   assign w_bright = (pix_val > COL_SZ'(THRESHOLD));

`ifdef STAR_RUN_SKIP_EN
   logic r_skip;

   // A run ends on a dim pixel or at the row edge; the wrap clears it too.
   always_ff @(posedge clk) begin
      if (reset || w_clr) begin
         r_skip <= 1'b0;
      end else if (r_state == S_FOUND && trace_done) begin
         r_skip <= !w_xmax;
      end else if (r_state == S_COMPARE && (!w_bright || w_xmax)) begin
         r_skip <= 1'b0;
      end
   end

   assign w_skip = r_skip;
`else
   assign w_skip = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next  = r_state;
      w_adv   = 1'b0;
      w_clr   = 1'b0;
      w_latch = 1'b0;
      unique case (r_state)
         S_IDLE, S_DONE: begin
            if (start) begin
               w_clr  = 1'b1;
               w_next = S_READ;
            end
         end
         S_READ: begin
            w_next = S_COMPARE;
         end
         S_COMPARE: begin
            if (w_bright && !w_skip) begin
               w_latch = 1'b1;
               w_next  = S_FOUND;
            end else if (w_last) begin
               w_next = S_DONE;
            end else begin
               w_adv  = 1'b1;
               w_next = S_READ;
            end
         end
         S_FOUND: begin
            if (trace_done) begin
               if (w_last) begin
                  w_next = S_DONE;
               end else begin
                  w_adv  = 1'b1;
                  w_next = S_READ;
               end
            end
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset || w_clr) begin
         r_x <= '0;
         r_y <= '0;
      end else if (w_adv) begin
         if (w_xmax) begin
            r_x <= '0;
            r_y <= r_y + Y_SZ'(1);
         end else begin
            r_x <= r_x + X_SZ'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_x_out     <= '0;
         r_y_out     <= '0;
         r_was_found <= 1'b0;
      end else begin
         r_was_found <= (r_state == S_FOUND);
         if (w_latch) begin
            r_x_out <= r_x;
            r_y_out <= r_y;
         end
      end
   end

   assign mem_address = ADDR_SZ'(r_y) * ADDR_SZ'(WIDTH) + ADDR_SZ'(r_x);
   assign x_out       = r_x_out;
   assign y_out       = r_y_out;
   assign star_found  = (r_state == S_FOUND);
   // Low only on the entry cycle of FOUND to restart the finder.
   assign star_foundn = !((r_state == S_FOUND) && !r_was_found);
   assign busy        = (r_state == S_READ) || (r_state == S_COMPARE) ||
                        (r_state == S_FOUND);
   assign frame_done  = (r_state == S_DONE);

endmodule

// File: tb/tb_star_raster_scanner.sv
// Scoreboard bench for star_raster_scanner: expected reports queued per frame,
// a monitor pops on each star_foundn pulse; frame timing checked directly.
module tb_star_raster_scanner;

   logic       clk;
   logic       reset;
   logic       start;
   logic       trace_done;
   logic [2:0] pix_val;
   logic [5:0] mem_address;
   logic [2:0] x_out;
   logic [2:0] y_out;
   logic       star_found;
   logic       star_foundn;
   logic       busy;
   logic       frame_done;

   typedef struct {
      int x;
      int y;
   } rep_t;

   rep_t       sb[$];
   logic [2:0] img [64];
   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;

   star_raster_scanner dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .trace_done  (trace_done),
      .pix_val     (pix_val),
      .mem_address (mem_address),
      .x_out       (x_out),
      .y_out       (y_out),
      .star_found  (star_found),
      .star_foundn (star_foundn),
      .busy        (busy),
      .frame_done  (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) pix_val <= img[mem_address];

   task automatic chk(input bit ok, input string nm, input int act, input int exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      rep_t e;
      if (!reset && star_foundn === 1'b0) begin
         if (sb.size() == 0) begin
            chk(1'b0, "unexpected_report", int'({y_out, x_out}), -1);
         end else begin
            e = sb.pop_front();
            chk(int'(x_out) == e.x, "rep_x", int'(x_out), e.x);
            chk(int'(y_out) == e.y, "rep_y", int'(y_out), e.y);
            chk(star_found === 1'b1, "rep_found", int'(star_found), 1);
         end
      end
   end

   task automatic clear_img();
      for (int i = 0; i < 64; i++) img[i] = 3'd0;
   endtask

   task automatic expect_rep(input int x, input int y);
      rep_t e;
      e.x = x;
      e.y = y;
      sb.push_back(e);
   endtask

   task automatic run_frame(input int exp_done, input int f_cyc, input int f_addr,
                            input int td_addr, input bit hyg);
      int t0, c, fc, td, nf;
      bit done;
      @(negedge clk);
      start = 1'b1;
      t0 = cyc;
      @(negedge clk);
      start = 1'b0;
      chk(mem_address == 6'd0, "start_addr0", int'(mem_address), 0);
      chk(busy === 1'b1 && frame_done === 1'b0, "start_busy",
          int'({busy, frame_done}), 2);
      fc = -100;
      td = -100;
      nf = 0;
      done = 1'b0;
      for (int k = 0; k < 300 && !done; k++) begin
         c = cyc - t0;
         if (frame_done === 1'b1) begin
            done = 1'b1;
            chk(c == exp_done, "done_cycle", c, exp_done);
            chk(star_found === 1'b0, "done_nofound", int'(star_found), 0);
         end else begin
            if (star_foundn === 1'b0) begin
               fc = c;
               nf++;
               if (nf == 1 && f_cyc >= 0) chk(c == f_cyc, "found_cycle", c, f_cyc);
               if (nf == 1 && f_addr >= 0)
                  chk(int'(mem_address) == f_addr, "found_addr", int'(mem_address), f_addr);
            end
            if (c == fc + 6) begin
               trace_done = 1'b1;
               td = c;
            end
            if (hyg && c == fc + 2) start = 1'b1;
            if (hyg && c == fc + 3)
               chk(star_found === 1'b1, "found_hold", int'(star_found), 1);
            if (c == td + 1) begin
               chk(star_found === 1'b0, "found_drop", int'(star_found), 0);
               if (nf == 1 && td_addr >= 0)
                  chk(int'(mem_address) == td_addr, "resume_addr", int'(mem_address), td_addr);
            end
            if (hyg && nf == 1 && c == td + 3) trace_done = 1'b1;
            if (hyg && nf == 1 && c == td + 4)
               chk(int'(mem_address) == td_addr + 1 && busy === 1'b1, "td_ignored",
                   int'(mem_address), td_addr + 1);
            @(negedge clk);
            start = 1'b0;
            trace_done = 1'b0;
         end
      end
      if (!done) chk(1'b0, "frame_timeout", c, exp_done);
   endtask

   task automatic check_reset_state(input string nm);
      chk(mem_address == 6'd0, {nm, "_addr"}, int'(mem_address), 0);
      chk(x_out == 3'd0 && y_out == 3'd0, {nm, "_xy"}, int'({y_out, x_out}), 0);
      chk(star_found === 1'b0 && star_foundn === 1'b1, {nm, "_found"},
          int'({star_found, star_foundn}), 1);
      chk(busy === 1'b0 && frame_done === 1'b0, {nm, "_busy"},
          int'({busy, frame_done}), 0);
   endtask

   initial begin
      int t0, c, fc;
      bit hit;
      reset = 1'b1;
      start = 1'b0;
      trace_done = 1'b0;
      clear_img();
      repeat (3) @(negedge clk);
      check_reset_state("rst");
      reset = 1'b0;
      @(negedge clk);
      chk(busy === 1'b0, "idle_busy", int'(busy), 0);

      // reset in COMPARE of (3,2) after one report at (1,0)
      clear_img();
      img[1] = 3'd2;
      expect_rep(1, 0);
      start = 1'b1;
      t0 = cyc;
      fc = -100;
      hit = 1'b0;
      for (int k = 0; k < 80 && !hit; k++) begin
         @(negedge clk);
         start = 1'b0;
         trace_done = 1'b0;
         c = cyc - t0;
         if (star_foundn === 1'b0) fc = c;
         if (c == fc + 6) trace_done = 1'b1;
         if (c == 39) begin
            hit = 1'b1;
            chk(mem_address == 6'd15, "pre_reset_addr", int'(mem_address), 15);
            chk(x_out == 3'd1, "pre_reset_x", int'(x_out), 1);
            reset = 1'b1;
            start = 1'b1;
            trace_done = 1'b1;
         end
      end
      if (!hit) chk(1'b0, "reset_timeout", c, 39);
      @(negedge clk);
      check_reset_state("midrst");
      reset = 1'b0;
      start = 1'b0;
      trace_done = 1'b0;
      @(negedge clk);
      chk(busy === 1'b0, "post_rst_idle", int'(busy), 0);

      // empty frame after reset
      clear_img();
      run_frame(73, -1, -1, -1, 1'b0);

      // single star (2,1) with ignored start/trace_done pulses
      clear_img();
      img[8] = 3'd5;
      expect_rep(2, 1);
      run_frame(80, 19, 8, 9, 1'b1);

      // horizontal run plus one isolated star
      clear_img();
      img[8] = 3'd7;
      img[9] = 3'd7;
      img[10] = 3'd7;
      img[18] = 3'd4;
      expect_rep(2, 1);
`ifdef STAR_RUN_SKIP_EN
      expect_rep(0, 3);
      run_frame(87, 19, 8, 9, 1'b0);
`else
      expect_rep(3, 1);
      expect_rep(4, 1);
      expect_rep(0, 3);
      run_frame(101, 19, 8, 9, 1'b0);
`endif

      // row wrap
      clear_img();
      img[5] = 3'd1;
      expect_rep(5, 0);
      run_frame(80, 13, 5, 6, 1'b0);

      // last pixel
      clear_img();
      img[35] = 3'd3;
      expect_rep(5, 5);
      run_frame(80, 73, 35, -1, 1'b0);

      // restart from DONE
      clear_img();
      run_frame(73, -1, -1, -1, 1'b0);

      @(negedge clk);
      chk(sb.size() == 0, "sb_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
